// File: rtl/spi_slave_xfer.sv
// spi_slave_xfer: oversampled SPI slave with configurable word width,
// CPOL/CPHA mode and bit order, multi-word frames and a single-entry TX
// holding register with a valid/ready handshake.
//
// state  | meaning
// IDLE   | SS inactive (or frame ignored after reset); MISO undriven
// ACTIVE | frame in progress; sampling MOSI and shifting MISO
module spi_slave_xfer #(
  parameter int                DATA_W      = 8,
  parameter int                CPOL        = 0,
  parameter int                CPHA        = 0,
  parameter int                MSB_FIRST   = 1,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] TX_IDLE     = '0
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              sck_i,
  input  logic              mosi_i,
  input  logic              ss_n_i,
  output logic              miso_o,
  output logic              miso_oe_o,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  output logic              busy_o,
  output logic              tx_underrun_o
);

  localparam int                CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic              SCK_IDLE = (CPOL != 0);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] ss_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sck_d;
  logic                   ss_d;
  logic [SYNC_STAGES:0]   settle;
  logic                   armed;

  logic [0:0]             state;
  logic [CNT_W-1:0]       cnt;
  logic                   load_pend;
  logic [DATA_W-1:0]      rx_sreg;
  logic                   rx_done;

  logic                   hold_full;
  logic [DATA_W-1:0]      hold_data;
  logic [DATA_W-1:0]      tx_sreg;
  logic                   miso_q;

  logic sck_s, ss_s, mosi_s;
  logic lead_edge, trail_edge, sample_edge, shift_edge;
  logic ss_fall, ss_rise;
  logic active, do_shift, load, tx_write, tx_bit;
  logic [DATA_W-1:0] rx_next, tx_shifted;

  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // Input synchronisers plus the extra SCK/SS flop used for edge detection.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sck_sync  <= {SYNC_STAGES{SCK_IDLE}};
      ss_sync   <= '1;
      mosi_sync <= '0;
      sck_d     <= SCK_IDLE;
      ss_d      <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck_i};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n_i};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_i};
      sck_d     <= sck_s;
      ss_d      <= ss_s;
    end
  end

  // SS falls are only honoured once SS has been seen high with the chain
  // refilled from the pin, so a frame already running at reset release is
  // ignored until the master deasserts and reasserts SS.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      settle <= '0;
      armed  <= 1'b0;
    end else begin
      settle <= {settle[SYNC_STAGES-1:0], 1'b1};
      if (settle[SYNC_STAGES] && ss_d)
        armed <= 1'b1;
    end
  end

  // Edge classification and per-cycle control decisions.
  always_comb begin
    lead_edge   = (sck_s != SCK_IDLE) && (sck_d == SCK_IDLE);
    trail_edge  = (sck_s == SCK_IDLE) && (sck_d != SCK_IDLE);
    sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
    shift_edge  = (CPHA != 0) ? lead_edge : trail_edge;
    ss_fall     = armed && ss_d && !ss_s;
    ss_rise     = ss_s && !ss_d;
    active      = (state == ST_ACTIVE);
    // An SS rise wins over a coincident shift edge: no load after the frame ends.
    do_shift    = active && !ss_rise && shift_edge;
    load        = ((state == ST_IDLE) && ss_fall && (CPHA == 0)) ||
                  (do_shift && (load_pend || ((CPHA != 0) && (cnt == '0))));
    tx_write    = tx_valid_i && !hold_full;
    rx_next     = (MSB_FIRST != 0) ? {rx_sreg[DATA_W-2:0], mosi_s}
                                   : {mosi_s, rx_sreg[DATA_W-1:1]};
    tx_shifted  = (MSB_FIRST != 0) ? {tx_sreg[DATA_W-2:0], 1'b0}
                                   : {1'b0, tx_sreg[DATA_W-1:1]};
    tx_bit      = (MSB_FIRST != 0) ? tx_sreg[DATA_W-1] : tx_sreg[0];
  end

  // Frame FSM, bit counter and RX shift register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      load_pend <= 1'b0;
      rx_sreg   <= '0;
      rx_done   <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ss_fall)
            state <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (ss_rise) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            load_pend <= 1'b0;
          end else if (sample_edge) begin
            rx_sreg <= rx_next;
            if (cnt == CNT_LAST) begin
              cnt       <= '0;
              rx_done   <= 1'b1;
              load_pend <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else if (shift_edge) begin
            load_pend <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Publish a completed word one cycle after its final sample.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rx_data_o  <= '0;
      rx_valid_o <= 1'b0;
    end else begin
      rx_valid_o <= rx_done;
      if (rx_done)
        rx_data_o <= rx_sreg;
    end
  end

  // TX holding register and shift register; an empty load sends TX_IDLE.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      hold_full     <= 1'b0;
      hold_data     <= '0;
      tx_sreg       <= TX_IDLE;
      tx_underrun_o <= 1'b0;
    end else begin
      tx_underrun_o <= load && !hold_full;
      if (load)
        tx_sreg <= hold_full ? hold_data : TX_IDLE;
      else if (do_shift)
        tx_sreg <= tx_shifted;
      if (tx_write)
        hold_data <= tx_data_i;
      if (load && hold_full)
        hold_full <= 1'b0;
      else if (tx_write)
        hold_full <= 1'b1;
    end
  end

  // Registered MISO bit so the pin changes a fixed time after the shift edge.
  always_ff @(posedge clk_i) begin
    if (reset_i)
      miso_q <= 1'b0;
    else
      miso_q <= active ? tx_bit : 1'b0;
  end

  assign miso_o     = miso_q && active;
  assign miso_oe_o  = active;
  assign busy_o     = active;
  assign tx_ready_o = !hold_full;

endmodule
